// File: rtl/cordic_rx_pkg.sv
// Shared constants and types for the cordic_wrapper receive buffer.
package cordic_rx_pkg;

  localparam int RX_DATA_W     = 56;
  localparam int RX_DROP_CNT_W = 16;

  typedef logic [RX_DATA_W-1:0] cordic_word_t;

  // Pointer/count width: one extra bit beyond the index so full and empty are distinguishable.
  function automatic int rx_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cordic_rx_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module cordic_rx_mem #(
  parameter int DATA_WIDTH = 56,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cordic_rx_buffer.sv
// FWFT receive buffer for the CORDIC result stream; flags beats dropped while full.
// Optional CORDIC_RX_DROP_CNT_EN adds a saturating 16-bit drop counter on o_drop_cnt.
module cordic_rx_buffer
  import cordic_rx_pkg::*;
#(
  parameter int  DATA_WIDTH = RX_DATA_W,
  parameter int  DEPTH      = 8,
  localparam int CNT_WIDTH  = rx_ptr_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_async_rst,
  input  logic                  i_en,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_rdy,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_WIDTH-1:0]  o_count,
`ifdef CORDIC_RX_DROP_CNT_EN
  output logic [RX_DROP_CNT_W-1:0] o_drop_cnt,
`endif
  output logic                  o_overflow,
  input  logic                  i_clr_ovf
);

  localparam int AW = CNT_WIDTH - 1;

  logic [CNT_WIDTH-1:0]  wr_ptr, rd_ptr, count;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full, empty, push, pop, drop, ovf;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && i_rdy;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push  = i_en && i_vld && (!full || pop);
  assign drop  = i_en && i_vld && full && !pop;

  cordic_rx_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .i_clk (i_clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (i_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_WIDTH'(1);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (pop && !push) count <= count - CNT_WIDTH'(1);
      // Set has priority over clear so a drop is never lost.
      if (drop)           ovf <= 1'b1;
      else if (i_clr_ovf) ovf <= 1'b0;
    end
  end

`ifdef CORDIC_RX_DROP_CNT_EN
  logic [RX_DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst)                drop_cnt <= '0;
    else if (i_clr_ovf)             drop_cnt <= drop ? RX_DROP_CNT_W'(1) : '0;
    else if (drop && !(&drop_cnt))  drop_cnt <= drop_cnt + RX_DROP_CNT_W'(1);
  end

  assign o_drop_cnt = drop_cnt;
`endif

  assign o_vld      = !empty;
  assign o_data     = empty ? '0 : rdata;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count;
  assign o_overflow = ovf;

endmodule

// File: tb/tb_cordic_rx_buffer.sv
// Directed self-checking bench for cordic_rx_buffer (DEPTH=8, DATA_WIDTH=56).
module tb_cordic_rx_buffer;

  localparam int DW = 56;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_async_rst = 1'b1;
  logic          i_en = 1'b0, i_vld = 1'b0, i_rdy = 1'b0, i_clr_ovf = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_vld, o_full, o_empty, o_overflow;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
`ifdef CORDIC_RX_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  int passed = 0;
  int total  = 0;

  cordic_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
    .i_clk       (i_clk),
    .i_async_rst (i_async_rst),
    .i_en        (i_en),
    .i_vld       (i_vld),
    .i_data      (i_data),
    .o_vld       (o_vld),
    .o_data      (o_data),
    .i_rdy       (i_rdy),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
`ifdef CORDIC_RX_DROP_CNT_EN
    .o_drop_cnt  (o_drop_cnt),
`endif
    .o_overflow  (o_overflow),
    .i_clr_ovf   (i_clr_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset held, then idle
    tick();
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    i_async_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_vld", 64'(o_vld), 64'd0);
      chk("idle_empty", 64'(o_empty), 64'd1);
      chk("idle_count", 64'(o_count), 64'd0);
      chk("idle_ovf", 64'(o_overflow), 64'd0);
    end

    // Single beat, FWFT after one cycle
    i_en = 1'b1; i_vld = 1'b1; i_data = 56'h00_1234_5678_9ABC;
    tick();
    i_vld = 1'b0;
    chk("one_vld", 64'(o_vld), 64'd1);
    chk("one_data", 64'(o_data), 64'h00_1234_5678_9ABC);
    chk("one_count", 64'(o_count), 64'd1);
    i_rdy = 1'b1;
    tick();
    i_rdy = 1'b0;
    chk("one_empty", 64'(o_empty), 64'd1);
    chk("one_count0", 64'(o_count), 64'd0);

    // Burst 1..10 with no reads: 8 stored, 2 dropped
    for (int k = 1; k <= 10; k++) begin
      i_vld = 1'b1; i_data = DW'(k);
      tick();
      if (k == 7) chk("burst_nfull7", 64'(o_full), 64'd0);
      if (k == 8) begin
        chk("burst_full", 64'(o_full), 64'd1);
        chk("burst_count", 64'(o_count), 64'd8);
        chk("burst_ovf8", 64'(o_overflow), 64'd0);
      end
      if (k == 9) chk("burst_ovf9", 64'(o_overflow), 64'd1);
    end
    i_vld = 1'b0;
`ifdef CORDIC_RX_DROP_CNT_EN
    chk("burst_dropcnt", 64'(o_drop_cnt), 64'd2);
`endif
    chk("burst_count10", 64'(o_count), 64'd8);
    i_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_vld", 64'(o_vld), 64'd1);
      chk("drain_data", 64'(o_data), 64'(k));
      tick();
    end
    i_rdy = 1'b0;
    chk("drain_empty", 64'(o_empty), 64'd1);
    chk("drain_ovf_sticky", 64'(o_overflow), 64'd1);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("clr_ovf", 64'(o_overflow), 64'd0);
`ifdef CORDIC_RX_DROP_CNT_EN
    chk("clr_dropcnt", 64'(o_drop_cnt), 64'd0);
`endif

    // Fill with 100..107, then stream push+pop for 16 cycles while full
    for (int k = 0; k < 8; k++) begin
      i_vld = 1'b1; i_data = DW'(100 + k);
      tick();
    end
    chk("fill_full", 64'(o_full), 64'd1);
    i_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_data = DW'(108 + k);
      chk("stream_data", 64'(o_data), 64'(100 + k));
      tick();
      chk("stream_count", 64'(o_count), 64'd8);
      chk("stream_ovf", 64'(o_overflow), 64'd0);
    end
    i_vld = 1'b0; i_rdy = 1'b0;
    chk("stream_head", 64'(o_data), 64'd116);

    // Disabled capture while full never counts as a drop
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_vld = 1'b1; i_data = DW'(500 + k);
      tick();
      i_vld = 1'b0;
      tick();
    end
    chk("en0_ovf", 64'(o_overflow), 64'd0);
    chk("en0_count", 64'(o_count), 64'd8);
    chk("en0_head", 64'(o_data), 64'd116);
    // Drop coinciding with clear: set wins
    i_en = 1'b1; i_vld = 1'b1; i_clr_ovf = 1'b1; i_data = DW'(999);
    tick();
    i_vld = 1'b0; i_clr_ovf = 1'b0;
    chk("setwins_ovf", 64'(o_overflow), 64'd1);
`ifdef CORDIC_RX_DROP_CNT_EN
    chk("setwins_dropcnt", 64'(o_drop_cnt), 64'd1);
`endif
    chk("setwins_head", 64'(o_data), 64'd116);

    // Flush, hold 5 entries, then async reset mid-burst
    i_async_rst = 1'b1;
    #2;
    chk("flush_vld", 64'(o_vld), 64'd0);
    i_async_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_vld = 1'b1; i_data = DW'(200 + k);
      tick();
    end
    chk("hold5_count", 64'(o_count), 64'd5);
    chk("hold5_head", 64'(o_data), 64'd200);
    i_data = DW'(205);
    #2;
    i_async_rst = 1'b1;
    #1;
    chk("arst_vld", 64'(o_vld), 64'd0);
    chk("arst_count", 64'(o_count), 64'd0);
    chk("arst_empty", 64'(o_empty), 64'd1);
    chk("arst_ovf", 64'(o_overflow), 64'd0);
    tick();
    chk("arst_hold_count", 64'(o_count), 64'd0);
    i_async_rst = 1'b0;
    i_vld = 1'b0;
    tick();
    chk("post_rst_vld", 64'(o_vld), 64'd0);
    for (int k = 0; k < 3; k++) begin
      i_vld = 1'b1; i_data = DW'(300 + k);
      tick();
    end
    i_vld = 1'b0;
    chk("post_count", 64'(o_count), 64'd3);
    i_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("post_data", 64'(o_data), 64'(300 + k));
      tick();
    end
    i_rdy = 1'b0;
    chk("post_empty", 64'(o_empty), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cordic_rx_buffer.md
Name: cordic_rx_buffer

Overview:
- Receive-side buffer for the cordic_wrapper result stream.
- Captures every i_vld/i_data beat driven by the CORDIC datapath. That datapath has no backpressure, so the buffer must absorb bursts.
- Re-presents results to the downstream consumer (systolic array feeder or scan readout) over a first-word-fall-through valid/ready interface.
- Flags any results it was forced to drop.

Parameters:
- DATA_WIDTH, 56, width of one CORDIC result word (matches cordic_wrapper DATA_WIDTH).
- DEPTH, 8, number of buffered entries; power of two, at least 2.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_async_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  capture enable; when low, incoming beats are ignored.
- i_vld  in  1  result valid from cordic_wrapper (its o_vld).
- i_data  in  DATA_WIDTH  result word from cordic_wrapper (its o_data).
- o_vld  out  1  head entry valid toward consumer.
- o_data  out  DATA_WIDTH  head entry data.
- i_rdy  in  1  consumer ready; a pop occurs when o_vld and i_rdy are both high.
- o_full  out  1  occupancy equals DEPTH.
- o_empty  out  1  occupancy equals 0.
- o_count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: at least one beat was dropped.
- i_clr_ovf  in  1  synchronous clear of o_overflow.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count go to 0; o_overflow goes to 0.
  - o_vld=0, o_empty=1, o_full=0, o_count=0; o_data is don't-care and driven to 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation flushes all entries immediately; no partial pop or push completes.
- Push: push = i_en & i_vld & (!full | pop).
  - Writes i_data at wr_ptr, then increments wr_ptr.
- Pop: pop = o_vld & i_rdy. Increments rd_ptr.
- Pointers: CNT_WIDTH bits each.
  - Index is the low $clog2(DEPTH) bits; wraps naturally.
  - full: pointer MSBs differ and indices are equal. empty: pointers are equal.
- FWFT timing:
  - o_vld = !empty.
  - o_data = mem[rd_idx], from the registered pointer and synchronous-write storage.
  - A word pushed into an empty buffer appears on o_data/o_vld exactly 1 cycle after capture.
  - Zero-cycle bypass is not permitted.
- Count: o_count updates registered, with the same timing as the pointers.
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
- Simultaneous push and pop:
  - When full: both proceed and count stays DEPTH; no overflow.
  - When empty: pop is impossible (o_vld=0), so only the push proceeds.
- Drop:
  - A beat is dropped when i_en & i_vld & full & !pop.
  - On a drop, o_overflow is set on the next edge and data is discarded.
  - Beats with i_en=0 are never counted as drops.
- Overflow set and clear in the same cycle: set wins.
- i_en=0: reads continue normally; the buffer drains.
- No internal FSM beyond the pointers. Behaviour is fully defined by the push/pop/drop equations above.

Optional Feature:
- Macro: CORDIC_RX_DROP_CNT_EN.
- When defined:
  - Adds output port o_drop_cnt [15:0].
  - Counter increments by 1 on each dropped beat and saturates at 16'hFFFF.
  - Cleared by reset and by i_clr_ovf. A drop in the same cycle as i_clr_ovf yields o_drop_cnt=1.
- When undefined: no port, no counter logic. o_overflow behaves identically in both builds.

Decomposition:
- Package cordic_rx_pkg:
  - localparam RX_DROP_CNT_W=16.
  - typedef logic [DATA_WIDTH-1:0] cordic_word_t (DATA_WIDTH as a package constant default of 56).
  - Pointer/count width helper function clog2-based.
- Sub-module cordic_rx_mem:
  - Simple dual-port storage: write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
  - The top level owns all pointer, flag and overflow logic.

Test Plan (DEPTH=8, DATA_WIDTH=56):
- Reset then idle: o_vld=0, o_empty=1, o_count=0, o_overflow=0 for 10 cycles.
- Single beat 56'h00_1234_5678_9ABC with i_rdy=0: o_vld=1 and o_data matches on the following cycle; o_count=1. Assert i_rdy for one cycle: o_empty=1 next cycle.
- Burst of 10 beats (values 1..10) with i_rdy=0:
  - o_full=1 after the 8th, o_count=8.
  - o_overflow=1 after the 9th; o_drop_cnt=2 when built with CORDIC_RX_DROP_CNT_EN.
  - Drain yields exactly 1..8 in order.
- Full buffer with continuous push (values 100..) and i_rdy=1 for 16 cycles: no overflow, o_count stays 8, output order continuous, pointers wrap twice.
- i_en=0 with i_vld pulses while full: o_overflow stays 0, contents unchanged. Then pulse i_clr_ovf together with a real drop: o_overflow stays 1.
- Assert i_async_rst mid-burst with 5 entries held: outputs return to reset values immediately (o_vld=0, o_count=0). Post-reset pushes are read back starting from the new data.
